// File: rtl/wbvga_ctrl.sv
// VGA frame-buffer control: Wishbone register file with double-buffered base/timing and a disable/drain/re-enable sequencer.
// Latency: bus ack one cycle after strobe; register effects and active-output commits appear one cycle after the causing edge.
// Backpressure: never stalls the bus; timing updates hold the datapath off for at least HOLD cycles and until i_vid_cyc drops.
// Ports: i_clk/i_reset_n; Wishbone slave (i_wb_cyc/stb/we/addr/data/sel, o_wb_stall/ack/data);
//        i_frame and i_vid_cyc from the frame module; o_en/o_test, o_base_addr, o_line_words,
//        o_hm_* / o_vm_* active timing; o_interrupt (level, frame IRQ flag gated by IRQEN).
module wbvga_ctrl #(
  parameter int          AW       = 24,
  parameter int          FW       = 13,
  parameter int          LW       = 12,
  parameter int          HOLD     = 16,
  // Packed 16-bit fields, most significant first: width/height, porch, synch, raw.
  parameter logic [63:0] DEF_H    = {16'd640, 16'd656, 16'd752, 16'd800},
  parameter logic [63:0] DEF_V    = {16'd480, 16'd490, 16'd492, 16'd525},
  parameter int          DEF_LINE = 640
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [2:0]    i_wb_addr,
  input  logic [31:0]   i_wb_data,
  input  logic [3:0]    i_wb_sel,
  output logic          o_wb_stall,
  output logic          o_wb_ack,
  output logic [31:0]   o_wb_data,
  input  logic          i_frame,
  input  logic          i_vid_cyc,
  output logic          o_en,
  output logic          o_test,
  output logic [AW-1:0] o_base_addr,
  output logic [FW:0]   o_line_words,
  output logic [FW-1:0] o_hm_width,
  output logic [FW-1:0] o_hm_porch,
  output logic [FW-1:0] o_hm_synch,
  output logic [FW-1:0] o_hm_raw,
  output logic [LW-1:0] o_vm_height,
  output logic [LW-1:0] o_vm_porch,
  output logic [LW-1:0] o_vm_synch,
  output logic [LW-1:0] o_vm_raw,
  output logic          o_interrupt
);

  localparam int              LNW    = FW + 1;
  localparam int              CW     = $clog2(HOLD + 1);
  localparam logic [CW-1:0]   HOLD_C = CW'(HOLD);
  localparam logic [LNW-1:0]  DLINE  = LNW'(DEF_LINE);
  localparam logic [FW-1:0]   DH_W   = DEF_H[48 +: FW];
  localparam logic [FW-1:0]   DH_P   = DEF_H[32 +: FW];
  localparam logic [FW-1:0]   DH_S   = DEF_H[16 +: FW];
  localparam logic [FW-1:0]   DH_R   = DEF_H[0  +: FW];
  localparam logic [LW-1:0]   DV_H   = DEF_V[48 +: LW];
  localparam logic [LW-1:0]   DV_P   = DEF_V[32 +: LW];
  localparam logic [LW-1:0]   DV_S   = DEF_V[16 +: LW];
  localparam logic [LW-1:0]   DV_R   = DEF_V[0  +: LW];

  typedef enum logic [1:0] {S_OFF, S_RUN, S_FLUSH, S_APPLY} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   hold_cnt;
  logic            commit_base, commit_shadow;
  logic            ctrl_en, ctrl_test, ctrl_irqen;
  logic [AW-1:0]   pend_base;
  logic            flip_pend, dirty;
  logic [LNW-1:0]  sh_line;
  logic [FW-1:0]   sh_hw, sh_hp, sh_hs, sh_hr;
  logic [LW-1:0]   sh_vh, sh_vp, sh_vs, sh_vr;
  logic [15:0]     frame_cnt;
  logic            irq_flag;
  logic [31:0]     rd_dat;

  // Byte-lane merge of a write into the current 32-bit register view.
  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  logic bus_stb, wr, shadow_wr, busy;
  assign bus_stb   = i_wb_cyc & i_wb_stb;
  assign wr        = bus_stb & i_wb_we;
  assign shadow_wr = wr && (i_wb_addr >= 3'd2) && (i_wb_addr <= 3'd6);
  assign busy      = (state == S_FLUSH) || (state == S_APPLY);

  logic [31:0] view_ha, view_hb, view_va, view_vb;
  assign view_ha = {16'(sh_hp), 16'(sh_hw)};
  assign view_hb = {16'(sh_hr), 16'(sh_hs)};
  assign view_va = {16'(sh_vp), 16'(sh_vh)};
  assign view_vb = {16'(sh_vr), 16'(sh_vs)};

  assign o_wb_stall  = 1'b0;
  assign o_en        = (state == S_RUN);
  assign o_test      = ctrl_test;
  assign o_interrupt = irq_flag & ctrl_irqen;

  always_comb begin
    rd_dat = '0;
    case (i_wb_addr)
      3'd0: rd_dat = {flip_pend, busy, 27'd0, ctrl_irqen, ctrl_test, ctrl_en};
      3'd1: rd_dat = 32'(pend_base);
      3'd2: rd_dat = 32'(o_line_words);
      3'd3: rd_dat = {16'(o_hm_porch), 16'(o_hm_width)};
      3'd4: rd_dat = {16'(o_hm_raw), 16'(o_hm_synch)};
      3'd5: rd_dat = {16'(o_vm_porch), 16'(o_vm_height)};
      3'd6: rd_dat = {16'(o_vm_raw), 16'(o_vm_synch)};
      default: rd_dat = {15'd0, irq_flag, frame_cnt};
    endcase
  end

  always_comb begin
    next_state    = state;
    commit_base   = 1'b0;
    commit_shadow = 1'b0;
    case (state)
      S_OFF: begin
        // Datapath is idle, so pending values can land immediately.
        commit_base   = flip_pend;
        commit_shadow = dirty;
        if (ctrl_en && !dirty) next_state = S_RUN;
      end
      S_RUN: begin
        commit_base = i_frame & flip_pend;
        if (!ctrl_en)   next_state = S_OFF;
        else if (dirty) next_state = S_FLUSH;
      end
      S_FLUSH: begin
        // A late shadow write restarts the hold, so never leave on that cycle.
        if (hold_cnt == '0 && !i_vid_cyc && !shadow_wr) next_state = S_APPLY;
      end
      S_APPLY: begin
        commit_base   = 1'b1;
        commit_shadow = 1'b1;
        next_state    = ctrl_en ? S_RUN : S_OFF;
      end
      default: next_state = S_OFF;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= S_OFF;
      hold_cnt     <= HOLD_C;
      ctrl_en      <= 1'b0;
      ctrl_test    <= 1'b0;
      ctrl_irqen   <= 1'b0;
      pend_base    <= '0;
      flip_pend    <= 1'b0;
      dirty        <= 1'b0;
      sh_line      <= DLINE;
      sh_hw <= DH_W;  sh_hp <= DH_P;  sh_hs <= DH_S;  sh_hr <= DH_R;
      sh_vh <= DV_H;  sh_vp <= DV_P;  sh_vs <= DV_S;  sh_vr <= DV_R;
      o_base_addr  <= '0;
      o_line_words <= DLINE;
      o_hm_width <= DH_W;  o_hm_porch <= DH_P;  o_hm_synch <= DH_S;  o_hm_raw <= DH_R;
      o_vm_height <= DV_H; o_vm_porch <= DV_P;  o_vm_synch <= DV_S;  o_vm_raw <= DV_R;
      frame_cnt    <= '0;
      irq_flag     <= 1'b0;
      o_wb_ack     <= 1'b0;
      o_wb_data    <= '0;
    end else begin
      state <= next_state;

      // Held at HOLD outside FLUSH so entry always starts a full count.
      if (state != S_FLUSH || shadow_wr) hold_cnt <= HOLD_C;
      else if (hold_cnt != '0)           hold_cnt <= hold_cnt - CW'(1);

      o_wb_ack <= bus_stb;
      if (bus_stb) o_wb_data <= rd_dat;

      // Commits come before bus writes so a same-cycle write stays pending.
      if (commit_base) begin
        o_base_addr <= pend_base;
        flip_pend   <= 1'b0;
      end
      if (commit_shadow) begin
        o_line_words <= sh_line;
        o_hm_width <= sh_hw;  o_hm_porch <= sh_hp;  o_hm_synch <= sh_hs;  o_hm_raw <= sh_hr;
        o_vm_height <= sh_vh; o_vm_porch <= sh_vp;  o_vm_synch <= sh_vs;  o_vm_raw <= sh_vr;
        dirty <= 1'b0;
      end

      if (wr && i_wb_addr == 3'd0 && i_wb_sel[0]) begin
        ctrl_en    <= i_wb_data[0];
        ctrl_test  <= i_wb_data[1];
        ctrl_irqen <= i_wb_data[2];
      end
      if (wr && i_wb_addr == 3'd1) begin
        pend_base <= AW'(wmerge(32'(pend_base), i_wb_data, i_wb_sel));
        flip_pend <= 1'b1;
      end
      if (shadow_wr) dirty <= 1'b1;
      if (wr) begin
        case (i_wb_addr)
          3'd2: sh_line <= LNW'(wmerge(32'(sh_line), i_wb_data, i_wb_sel));
          3'd3: begin
            sh_hw <= FW'(wmerge(view_ha, i_wb_data, i_wb_sel));
            sh_hp <= FW'(wmerge(view_ha, i_wb_data, i_wb_sel) >> 16);
          end
          3'd4: begin
            sh_hs <= FW'(wmerge(view_hb, i_wb_data, i_wb_sel));
            sh_hr <= FW'(wmerge(view_hb, i_wb_data, i_wb_sel) >> 16);
          end
          3'd5: begin
            sh_vh <= LW'(wmerge(view_va, i_wb_data, i_wb_sel));
            sh_vp <= LW'(wmerge(view_va, i_wb_data, i_wb_sel) >> 16);
          end
          3'd6: begin
            sh_vs <= LW'(wmerge(view_vb, i_wb_data, i_wb_sel));
            sh_vr <= LW'(wmerge(view_vb, i_wb_data, i_wb_sel) >> 16);
          end
          default: ;
        endcase
      end

      // A new frame outranks a software clear of the flag in the same cycle.
      if (i_frame) begin
        frame_cnt <= frame_cnt + 16'd1;
        irq_flag  <= 1'b1;
      end else if (wr && i_wb_addr == 3'd7 && i_wb_sel[2] && i_wb_data[16]) begin
        irq_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wbvga_ctrl.sv
module tb_wbvga_ctrl;
  localparam int AW = 24, FW = 13, LW = 12, HOLD = 16;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [2:0]    addr = '0;
  logic [31:0]   wdat = '0;
  logic [3:0]    sel = '0;
  logic          frame = 1'b0, vid_cyc = 1'b0;
  logic          o_wb_stall, o_wb_ack, o_en, o_test, o_interrupt;
  logic [31:0]   o_wb_data;
  logic [AW-1:0] o_base_addr;
  logic [FW:0]   o_line_words;
  logic [FW-1:0] o_hm_width, o_hm_porch, o_hm_synch, o_hm_raw;
  logic [LW-1:0] o_vm_height, o_vm_porch, o_vm_synch, o_vm_raw;

  wbvga_ctrl #(.AW(AW), .FW(FW), .LW(LW), .HOLD(HOLD)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdat), .i_wb_sel(sel),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
    .i_frame(frame), .i_vid_cyc(vid_cyc),
    .o_en(o_en), .o_test(o_test), .o_base_addr(o_base_addr), .o_line_words(o_line_words),
    .o_hm_width(o_hm_width), .o_hm_porch(o_hm_porch), .o_hm_synch(o_hm_synch), .o_hm_raw(o_hm_raw),
    .o_vm_height(o_vm_height), .o_vm_porch(o_vm_porch), .o_vm_synch(o_vm_synch), .o_vm_raw(o_vm_raw),
    .o_interrupt(o_interrupt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct { bit chk; logic [31:0] dat; int a; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model: register-level view of the block.
  bit          m_en, m_test, m_irqen, m_flip, m_dirty, m_irq;
  logic [31:0] m_pend, m_abase;
  logic [31:0] m_act[8];
  logic [31:0] m_sh[8];
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmask(input int a);
    logic [31:0] h, v;
    h = (32'd1 << FW) - 32'd1;
    v = (32'd1 << LW) - 32'd1;
    case (a)
      2:       return (32'd1 << (FW + 1)) - 32'd1;
      3, 4:    return h | (h << 16);
      default: return v | (v << 16);
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] bm;
    bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~bm) | (d & bm);
  endfunction

  task automatic model_reset();
    m_en = 0; m_test = 0; m_irqen = 0; m_flip = 0; m_dirty = 0; m_irq = 0;
    m_pend = 0; m_abase = 0; m_cnt = 0;
    for (int i = 0; i < 8; i++) m_act[i] = 0;
    m_act[2] = 32'd640;
    m_act[3] = {16'd656, 16'd640};
    m_act[4] = {16'd800, 16'd752};
    m_act[5] = {16'd490, 16'd480};
    m_act[6] = {16'd525, 16'd492};
    for (int i = 0; i < 8; i++) m_sh[i] = m_act[i];
  endtask

  function automatic logic [31:0] expect_rd(input int a);
    case (a)
      0:       return {m_flip, 1'b0, 27'd0, m_irqen, m_test, m_en};
      1:       return m_pend;
      7:       return {15'd0, m_irq, 16'(m_cnt)};
      default: return m_act[a];
    endcase
  endfunction

  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] s);
    case (a)
      0: if (s[0]) begin m_en = d[0]; m_test = d[1]; m_irqen = d[2]; end
      1: begin m_pend = merge(m_pend, d, s) & ((32'd1 << AW) - 32'd1); m_flip = 1; end
      7: if (s[2] && d[16]) m_irq = 0;
      default: begin m_sh[a] = merge(m_sh[a], d, s) & fmask(a); m_dirty = 1; end
    endcase
  endtask

  // A frame during normal running flips to the pending base.
  task automatic model_frame_commit();
    if (m_en && m_flip && !m_dirty) begin m_abase = m_pend; m_flip = 0; end
  endtask

  task automatic model_frame_count();
    m_cnt = (m_cnt + 1) & 32'hFFFF;
    m_irq = 1;
  endtask

  // One bus cycle, optionally with a coincident frame strobe. Called at posedge+1.
  task automatic bus(input bit w, input int a, input logic [31:0] d, input logic [3:0] s, input bit wf);
    exp_t e;
    e.chk = !w; e.dat = w ? 32'd0 : expect_rd(a); e.a = a;
    sb_q.push_back(e);
    if (wf) model_frame_commit();
    if (w) model_write(a, d, s);
    if (wf) model_frame_count();
    cyc = 1; stb = 1; we = w; addr = 3'(a); wdat = d; sel = s; frame = wf;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0; frame = 0;
  endtask

  task automatic frame_pulse();
    model_frame_commit();
    model_frame_count();
    frame = 1;
    @(posedge clk); #1;
    frame = 0;
  endtask

  // Enough idle cycles for any reconfiguration to complete.
  task automatic settle();
    vid_cyc = 0;
    repeat (HOLD + 8) @(posedge clk);
    #1;
    if ((m_dirty || !m_en) && m_flip) begin m_abase = m_pend; m_flip = 0; end
    if (m_dirty) begin
      for (int i = 2; i <= 6; i++) m_act[i] = m_sh[i];
      m_dirty = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".en"},     32'(o_en), 32'(m_en));
    chk({tag, ".test"},   32'(o_test), 32'(m_test));
    chk({tag, ".base"},   32'(o_base_addr), m_abase);
    chk({tag, ".line"},   32'(o_line_words), m_act[2]);
    chk({tag, ".hwidth"}, 32'(o_hm_width), m_act[3] & 32'h1FFF);
    chk({tag, ".hporch"}, 32'(o_hm_porch), m_act[3] >> 16);
    chk({tag, ".hsynch"}, 32'(o_hm_synch), m_act[4] & 32'h1FFF);
    chk({tag, ".hraw"},   32'(o_hm_raw), m_act[4] >> 16);
    chk({tag, ".vheight"},32'(o_vm_height), m_act[5] & 32'h0FFF);
    chk({tag, ".vporch"}, 32'(o_vm_porch), m_act[5] >> 16);
    chk({tag, ".vsynch"}, 32'(o_vm_synch), m_act[6] & 32'h0FFF);
    chk({tag, ".vraw"},   32'(o_vm_raw), m_act[6] >> 16);
    chk({tag, ".irq"},    32'(o_interrupt), 32'(m_irq & m_irqen));
    chk({tag, ".stall"},  32'(o_wb_stall), 32'd0);
  endtask

  // Monitor: ack must follow each strobe by exactly one cycle; read data from the scoreboard.
  logic exp_ack = 1'b0;
  always @(posedge clk) exp_ack <= rst_n & cyc & stb;

  always @(negedge clk) begin
    if (o_wb_ack || exp_ack) begin
      chk("ack_timing", 32'(o_wb_ack), 32'(exp_ack));
      if (o_wb_ack) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack_unexpected: got ack with empty scoreboard (t=%0t)", $time);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.chk) chk($sformatf("read_reg%0d", mon_e.a), o_wb_data, mon_e.dat);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit bad;
    logic [31:0] rd;
    logic [3:0]  rs;
    int          ra;

    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // Reset state
    check_outputs("reset");
    chk("reset.ack", 32'(o_wb_ack), 32'd0);
    bus(0, 3, 0, 4'hF, 0);
    bus(0, 7, 0, 4'hF, 0);

    // Enable: o_en two cycles after the strobe
    bus(1, 0, 32'd1, 4'hF, 0);
    chk("en_after_1cyc", 32'(o_en), 32'd0);
    @(posedge clk); #1;
    chk("en_after_2cyc", 32'(o_en), 32'd1);

    // Page flip waits for the frame strobe
    bus(1, 1, 32'h1000, 4'hF, 0);
    repeat (3) @(posedge clk); #1;
    chk("base_before_frame", 32'(o_base_addr), 32'd0);
    bus(0, 0, 0, 4'hF, 0);
    frame_pulse();
    chk("base_after_frame", 32'(o_base_addr), m_abase);
    bus(0, 0, 0, 4'hF, 0);

    // Timing change with the frame module still on the bus
    vid_cyc = 1;
    bus(1, 3, 32'h02A0_0320, 4'hF, 0);
    @(posedge clk); #1;
    bad = 0;
    repeat (HOLD + 10) begin
      if (o_en) bad = 1;
      @(posedge clk); #1;
    end
    chk("en_low_while_vid_cyc", 32'(bad), 32'd0);
    vid_cyc = 0;
    n = 0;
    while (!o_en && n < 50) begin @(posedge clk); #1; n++; end
    chk("en_rises_after_drain", 32'(o_en), 32'd1);
    chk("hm_width_800", 32'(o_hm_width), 32'd800);
    settle();
    check_outputs("reconf");

    // Shadow write during FLUSH restarts the hold
    bus(1, 5, $urandom, 4'hF, 0);
    repeat (8) @(posedge clk); #1;
    bus(1, 6, $urandom, 4'hF, 0);
    n = 0;
    while (!o_en && n < 200) begin @(posedge clk); #1; n++; end
    chk("en_rises_after_restart", 32'(o_en), 32'd1);
    chk("restart_hold_len", 32'(n >= HOLD), 32'd1);
    settle();
    check_outputs("restart");

    // BASE write coinciding with a frame
    bus(1, 1, 32'h4000, 4'hF, 0);
    bus(1, 1, 32'h2000, 4'hF, 1);
    chk("base_same_cycle_frame", 32'(o_base_addr), m_abase);
    bus(0, 0, 0, 4'hF, 0);
    bus(0, 1, 0, 4'hF, 0);
    frame_pulse();
    check_outputs("flip2");

    // Frame interrupt
    bus(1, 7, 32'h0001_0000, 4'b0100, 0);
    bus(1, 0, 32'd5, 4'b0001, 0);
    repeat (3) frame_pulse();
    check_outputs("irq_set");
    bus(0, 7, 0, 4'hF, 0);
    bus(1, 7, 32'h0001_0000, 4'b0100, 1);
    check_outputs("irq_clear_vs_frame");
    bus(1, 7, 32'h0001_0000, 4'b0100, 0);
    check_outputs("irq_cleared");
    bus(0, 7, 0, 4'hF, 0);

    // Reset during FLUSH
    bus(1, 4, 32'h1111_2222, 4'hF, 0);
    repeat (4) @(posedge clk); #1;
    rst_n = 0;
    #1;
    model_reset();
    check_outputs("rst_mid_flush");
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    repeat (3) @(posedge clk); #1;
    check_outputs("after_rst");
    bus(1, 4, 32'h0000_00AB, 4'b0001, 0);
    settle();
    check_outputs("after_rst_partial");
    bus(0, 4, 0, 4'hF, 0);

    // Randomized operation mix
    for (int it = 0; it < 60; it++) begin
      rd = $urandom;
      rs = 4'($urandom);
      case ($urandom_range(0, 5))
        0: bus(1, $urandom_range(2, 6), rd, rs, 0);
        1: bus(1, 1, rd, rs, 1'($urandom_range(0, 1)));
        2: begin
          rd[0] = ($urandom_range(0, 3) != 0);
          bus(1, 0, rd, rs, 0);
        end
        3: frame_pulse();
        4: bus(1, 7, rd, rs, 1'($urandom_range(0, 1)));
        default: bus(0, $urandom_range(0, 7), 0, 4'hF, 0);
      endcase
      settle();
      check_outputs($sformatf("rand%0d", it));
      ra = $urandom_range(0, 7);
      bus(0, ra, 0, 4'hF, 0);
    end

    repeat (3) @(posedge clk); #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
